// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: drives a req/ack memory port,
// aligns store lanes, extends load data and stalls the pipeline while busy.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] AluOutM,
    input  logic [31:0] StoreDataM,
    input  logic [3:0]  MemWriteM,
    input  logic        MemToRegM,
    input  logic [2:0]  RegWriteM,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] LoadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [31:0]        r_rdata, w_rdata_next;
    logic               r_bus_err, w_bus_err_next;

    logic [1:0]  w_off;
    logic        w_access, w_store, w_is_half, w_is_word;
    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_off     = AluOutM[1:0];
    assign w_store   = |MemWriteM;
    assign w_access  = MemToRegM | w_store;
    assign w_is_half = (MemToRegM & ((RegWriteM == 3'd2) | (RegWriteM == 3'd5)))
                     | (MemWriteM == 4'b0011);
    assign w_is_word = (MemToRegM & (RegWriteM == 3'd3)) | (MemWriteM == 4'b1111);
    assign MisalignM = (w_is_half & w_off[0]) | (w_is_word & (|w_off));

    assign dmem_addr  = {AluOutM[31:2], 2'b00};
    assign dmem_we    = w_store ? (MemWriteM << w_off) : 4'b0000;
    assign dmem_wdata = w_store ? (StoreDataM << {w_off, 3'b000}) : 32'h0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_rdata   <= w_rdata_next;
            r_bus_err <= w_bus_err_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_rdata_next   = r_rdata;
        w_bus_err_next = 1'b0;
        dmem_req       = 1'b0;
        StallM         = 1'b0;
        case (r_state)
            S_IDLE: begin
                dmem_req = w_access & ~MisalignM;
                StallM   = dmem_req;
                if (dmem_req && dmem_ack) begin
                    w_state_next = S_DONE;
                    w_rdata_next = dmem_rdata;
                end else if (dmem_req) begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = '0;
                end
            end
            S_WAIT: begin
                dmem_req = 1'b1;
                StallM   = 1'b1;
                if (dmem_ack) begin
                    w_state_next = S_DONE;
                    w_rdata_next = dmem_rdata;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_state_next   = S_DONE;
                    w_rdata_next   = '0;
                    w_bus_err_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        // Reset also silences the port combinationally: the instruction may
        // still be presented while the FSM is held in IDLE.
        if (!rst_n) begin
            dmem_req = 1'b0;
            StallM   = 1'b0;
        end
    end

    assign BusErrM   = r_bus_err;
    assign w_shifted = r_rdata >> {w_off, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = w_off[1] ? r_rdata[31:16] : r_rdata[15:0];

    always_comb begin
        LoadDataM = 32'h0;
        if (r_state == S_DONE && MemToRegM) begin
            case (RegWriteM)
                3'd1:    LoadDataM = {{24{w_byte[7]}}, w_byte};
                3'd2:    LoadDataM = {{16{w_half[15]}}, w_half};
                3'd3:    LoadDataM = r_rdata;
                3'd4:    LoadDataM = {24'h0, w_byte};
                3'd5:    LoadDataM = {16'h0, w_half};
                default: LoadDataM = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios plus random
// transactions compared against a transaction-level reference model.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] AluOutM, StoreDataM;
    logic [3:0]  MemWriteM;
    logic        MemToRegM;
    logic [2:0]  RegWriteM;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic [31:0] LoadDataM;
    logic        StallM, MisalignM, BusErrM;

    int n_checks = 0;
    int n_errors = 0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .AluOutM(AluOutM), .StoreDataM(StoreDataM), .MemWriteM(MemWriteM),
        .MemToRegM(MemToRegM), .RegWriteM(RegWriteM),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .LoadDataM(LoadDataM), .StallM(StallM), .MisalignM(MisalignM),
        .BusErrM(BusErrM)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [2:0] rw);
        int unsigned off = addr % 4;
        int unsigned b   = (word / (32'd1 << (8 * off))) % 256;
        int unsigned h   = (word / ((addr % 4) >= 2 ? 32'h10000 : 32'h1)) % 65536;
        case (rw)
            3'd1:    return (b >= 128) ? (32'hFFFF_FF00 | b) : b;
            3'd2:    return (h >= 32768) ? (32'hFFFF_0000 | h) : h;
            3'd3:    return word;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    task automatic set_idle_inputs();
        AluOutM = 32'h0; StoreDataM = 32'h0; MemWriteM = 4'h0;
        MemToRegM = 1'b0; RegWriteM = 3'd0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    endtask

    // One instruction through MEM. delay = cycle index (0 = request cycle)
    // in which the memory acks; anything past TIMEOUT never acks in time.
    task automatic do_txn(input string tag, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [3:0] mask, input logic mtr, input logic [2:0] rw,
                          input int delay, input logic [31:0] rdata);
        bit          access, is_half, is_word, mis, timeout;
        logic [31:0] exp_wdata, exp_load;
        logic [3:0]  exp_we;
        int          exp_stall, n, berr;
        access    = mtr || (mask != 0);
        is_half   = (mtr && (rw == 2 || rw == 5)) || (mask == 4'b0011);
        is_word   = (mtr && rw == 3) || (mask == 4'b1111);
        mis       = (is_half && (addr % 2 != 0)) || (is_word && (addr % 4 != 0));
        timeout   = delay > TIMEOUT;
        exp_we    = 4'((mask * (1 << (addr % 4))) % 16);
        exp_wdata = (mask != 0) ? sdata * (32'd1 << (8 * (addr % 4))) : 32'h0;
        exp_load  = mtr ? model_load(timeout ? 32'h0 : rdata, addr, rw) : 32'h0;
        exp_stall = timeout ? TIMEOUT + 1 : delay + 1;

        @(posedge clk); #1;
        AluOutM = addr; StoreDataM = sdata; MemWriteM = mask;
        MemToRegM = mtr; RegWriteM = rw; dmem_rdata = rdata;
        dmem_ack = (delay == 0);
        @(negedge clk);
        check({tag, ":misalign"}, 32'(MisalignM), 32'(mis));
        check({tag, ":we"}, 32'(dmem_we), 32'(exp_we));
        check({tag, ":wdata"}, dmem_wdata, exp_wdata);
        if (!access || mis) begin
            check({tag, ":noreq"}, 32'(dmem_req), 32'h0);
            check({tag, ":nostall"}, 32'(StallM), 32'h0);
            check({tag, ":noload"}, LoadDataM, 32'h0);
            return;
        end
        check({tag, ":addr"}, dmem_addr, {addr[31:2], 2'b00});
        n = 0; berr = 0;
        while (StallM && n < 40) begin
            if (!dmem_req) berr += 100;
            if (BusErrM) berr++;
            n++;
            @(posedge clk); #1;
            dmem_ack = (n == delay);
            @(negedge clk);
        end
        check({tag, ":stall_len"}, 32'(n), 32'(exp_stall));
        check({tag, ":req_during_stall"}, 32'(berr), 32'h0);
        check({tag, ":done_req"}, 32'(dmem_req), 32'h0);
        check({tag, ":buserr"}, 32'(BusErrM), 32'(timeout));
        check({tag, ":load"}, LoadDataM, exp_load);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle_inputs();
        MemToRegM = 1'b1; RegWriteM = 3'd3; AluOutM = 32'h40;
        #12;
        check("rst:req", 32'(dmem_req), 32'h0);
        check("rst:stall", 32'(StallM), 32'h0);
        check("rst:buserr", 32'(BusErrM), 32'h0);
        check("rst:load", LoadDataM, 32'h0);
        set_idle_inputs();
        @(negedge clk); rst_n = 1'b1;

        do_txn("lw0", 32'h100, 32'h0, 4'h0, 1'b1, 3'd3, 0, 32'hDEADBEEF);
        do_txn("lb", 32'h103, 32'h0, 4'h0, 1'b1, 3'd1, 3, 32'h80123456);
        do_txn("lbu", 32'h103, 32'h0, 4'h0, 1'b1, 3'd4, 3, 32'h80123456);
        do_txn("sh", 32'h202, 32'h0000ABCD, 4'b0011, 1'b0, 3'd0, 1, 32'h0);
        do_txn("lw_mis", 32'h101, 32'h0, 4'h0, 1'b1, 3'd3, 0, 32'h12345678);
        do_txn("sh_mis", 32'h203, 32'h1234, 4'b0011, 1'b0, 3'd0, 0, 32'h0);
        do_txn("ack_last", 32'h104, 32'h0, 4'h0, 1'b1, 3'd3, 16, 32'hCAFEF00D);
        do_txn("timeout", 32'h108, 32'h0, 4'h0, 1'b1, 3'd3, 17, 32'h55555555);
        do_txn("after_to", 32'h10C, 32'h0, 4'h0, 1'b1, 3'd3, 0, 32'h0BADF00D);
        do_txn("lh_hi", 32'h112, 32'h0, 4'h0, 1'b1, 3'd2, 2, 32'h9ABC0001);
        do_txn("lhu_hi", 32'h112, 32'h0, 4'h0, 1'b1, 3'd5, 0, 32'h9ABC0001);
        do_txn("sb3", 32'h207, 32'h000000EE, 4'b0001, 1'b0, 3'd0, 0, 32'h0);
        do_txn("none", 32'h300, 32'h0, 4'h0, 1'b0, 3'd0, 0, 32'h0);

        // Reset asserted in the second WAIT cycle of a never-acked load.
        @(posedge clk); #1;
        AluOutM = 32'h300; MemToRegM = 1'b1; RegWriteM = 3'd3; dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rstw:stall_before", 32'(StallM), 32'h1);
        rst_n = 1'b0;
        #1;
        check("rstw:req", 32'(dmem_req), 32'h0);
        check("rstw:stall", 32'(StallM), 32'h0);
        @(negedge clk); set_idle_inputs();
        @(posedge clk); #3; rst_n = 1'b1;
        @(negedge clk);
        check("rstw:idle_req", 32'(dmem_req), 32'h0);
        check("rstw:buserr", 32'(BusErrM), 32'h0);
        do_txn("rstw:lw", 32'h304, 32'h0, 4'h0, 1'b1, 3'd3, 1, 32'h13579BDF);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, sd, rd;
            logic [3:0]  m;
            logic        mtr;
            logic [2:0]  rw;
            int          d, kind, sel;
            a    = ($urandom & 32'hFFFF_FFF0) | $urandom_range(0, 15);
            sd   = $urandom; rd = $urandom;
            kind = $urandom_range(0, 9);
            sel  = $urandom_range(0, 19);
            d    = (sel < 15) ? $urandom_range(0, 4) : (sel < 17) ? 16 : (sel < 19) ? 17 : 25;
            m = 4'h0; mtr = 1'b0; rw = 3'd0;
            if (kind < 5) begin
                mtr = 1'b1;
                rw  = (kind == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 5));
            end else if (kind < 9) begin
                case ($urandom_range(0, 2))
                    0:       m = 4'b0001;
                    1:       m = 4'b0011;
                    default: m = 4'b1111;
                endcase
            end
            do_txn($sformatf("rnd%0d", i), a, sd, m, mtr, rw, d, rd);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
